// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: buffering stage between the core's UART registers and the
// uart bit engine. A TX FIFO feeds start_tx/tx_value one byte at a time and an
// RX FIFO drains rx_value on rx_available, answering with rx_clear.
// While the RX FIFO is full the byte stays parked in the uart, which keeps
// request_to_send asserted as flow control.
// Optional feature: define UART_FIFO_LEVEL_EN to add the registered
// tx_level/rx_level occupancy ports.
module uart_fifo_bridge #(
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_push,
    input  logic [7:0] tx_data,
    output logic       tx_full,
    output logic       tx_busy,
    input  logic       rx_pop,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       start_tx,
    output logic [7:0] tx_value,
    input  logic       tx_done,
    input  logic       rx_available,
    input  logic [7:0] rx_value,
    output logic       rx_clear
`ifdef UART_FIFO_LEVEL_EN
    ,
    output logic [FIFO_DEPTH_LOG2:0] tx_level,
    output logic [FIFO_DEPTH_LOG2:0] rx_level
`endif
);

    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [AW:0] PTR_ZERO = {(AW + 1){1'b0}};
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    localparam logic [1:0] TX_IDLE    = 2'd0;
    localparam logic [1:0] TX_SEND    = 2'd1;
    localparam logic [1:0] TX_RELEASE = 2'd2;

    localparam logic [0:0] RX_IDLE  = 1'b0;
    localparam logic [0:0] RX_CLEAR = 1'b1;

    logic [7:0]  tx_mem_r [DEPTH];
    logic [7:0]  rx_mem_r [DEPTH];
    logic [AW:0] tx_wr_ptr_r;
    logic [AW:0] tx_rd_ptr_r;
    logic [AW:0] rx_wr_ptr_r;
    logic [AW:0] rx_rd_ptr_r;
    logic [1:0]  tx_state_r;
    logic [0:0]  rx_state_r;

    logic tx_empty_s;
    logic tx_full_s;
    logic rx_empty_s;
    logic rx_full_s;
    logic tx_push_s;
    logic tx_pop_s;
    logic rx_push_s;
    logic rx_pop_s;

    // FIFO status flags and the push/pop strobes, all from pre-edge state.
    always_comb begin
        tx_empty_s = (tx_wr_ptr_r == tx_rd_ptr_r);
        tx_full_s  = (tx_wr_ptr_r[AW] != tx_rd_ptr_r[AW]) &&
                     (tx_wr_ptr_r[AW-1:0] == tx_rd_ptr_r[AW-1:0]);
        rx_empty_s = (rx_wr_ptr_r == rx_rd_ptr_r);
        rx_full_s  = (rx_wr_ptr_r[AW] != rx_rd_ptr_r[AW]) &&
                     (rx_wr_ptr_r[AW-1:0] == rx_rd_ptr_r[AW-1:0]);
        tx_push_s  = tx_push && !tx_full_s;
        // The head byte stays in the FIFO while in flight; it leaves on tx_done.
        tx_pop_s   = (tx_state_r == TX_SEND) && tx_done;
        rx_push_s  = (rx_state_r == RX_IDLE) && rx_available && !rx_full_s;
        rx_pop_s   = rx_pop && !rx_empty_s;
    end

    // Core-facing status; rx_data reads as zero while the RX FIFO is empty.
    always_comb begin
        tx_full  = tx_full_s;
        tx_busy  = (tx_state_r != TX_IDLE) || !tx_empty_s;
        rx_empty = rx_empty_s;
        rx_data  = rx_empty_s ? 8'h00 : rx_mem_r[rx_rd_ptr_r[AW-1:0]];
    end

    // FIFO storage writes; contents are don't-care until a pointer covers them.
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_r[tx_wr_ptr_r[AW-1:0]] <= tx_data;
        end
        if (rx_push_s) begin
            rx_mem_r[rx_wr_ptr_r[AW-1:0]] <= rx_value;
        end
    end

    // TX FIFO pointers; reset discards any queued bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr_r <= PTR_ZERO;
            tx_rd_ptr_r <= PTR_ZERO;
        end else begin
            if (tx_push_s) begin
                tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
            end
            if (tx_pop_s) begin
                tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
            end
        end
    end

    // RX FIFO pointers; a pop on empty is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_ptr_r <= PTR_ZERO;
            rx_rd_ptr_r <= PTR_ZERO;
        end else begin
            if (rx_push_s) begin
                rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
            end
            if (rx_pop_s) begin
                rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
            end
        end
    end

    // TX handshake: launch head byte, hold until tx_done, then wait for the
    // uart to drop tx_done so it is idle before the next start_tx.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            start_tx   <= 1'b0;
            tx_value   <= 8'h00;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    if (!tx_empty_s) begin
                        tx_value   <= tx_mem_r[tx_rd_ptr_r[AW-1:0]];
                        start_tx   <= 1'b1;
                        tx_state_r <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tx_done) begin
                        start_tx   <= 1'b0;
                        tx_state_r <= TX_RELEASE;
                    end
                end
                TX_RELEASE: begin
                    if (!tx_done) begin
                        tx_state_r <= TX_IDLE;
                    end
                end
                default: begin
                    start_tx   <= 1'b0;
                    tx_state_r <= TX_IDLE;
                end
            endcase
        end
    end

    // RX handshake: capture the uart byte when there is room, hold rx_clear
    // until the uart withdraws rx_available.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_r <= RX_IDLE;
            rx_clear   <= 1'b0;
        end else begin
            case (rx_state_r)
                RX_IDLE: begin
                    if (rx_push_s) begin
                        rx_clear   <= 1'b1;
                        rx_state_r <= RX_CLEAR;
                    end
                end
                RX_CLEAR: begin
                    if (!rx_available) begin
                        rx_clear   <= 1'b0;
                        rx_state_r <= RX_IDLE;
                    end
                end
                default: begin
                    rx_clear   <= 1'b0;
                    rx_state_r <= RX_IDLE;
                end
            endcase
        end
    end

`ifdef UART_FIFO_LEVEL_EN
    // Occupancy counters tracking the same push/pop strobes as the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_level <= PTR_ZERO;
            rx_level <= PTR_ZERO;
        end else begin
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_level <= tx_level + PTR_ONE;
                2'b01:   tx_level <= tx_level - PTR_ONE;
                default: tx_level <= tx_level;
            endcase
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_level <= rx_level + PTR_ONE;
                2'b01:   rx_level <= rx_level - PTR_ONE;
                default: rx_level <= rx_level;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge: directed scenarios plus randomized
// traffic against queue-based reference models of both FIFOs and a small
// behavioural uart that answers start_tx and presents received bytes.
module tb_uart_fifo_bridge;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_push;
    logic [7:0] tx_data;
    logic       tx_full;
    logic       tx_busy;
    logic       rx_pop;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       start_tx;
    logic [7:0] tx_value;
    logic       tx_done;
    logic       rx_available;
    logic [7:0] rx_value;
    logic       rx_clear;
`ifdef UART_FIFO_LEVEL_EN
    logic [2:0] tx_level;
    logic [2:0] rx_level;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // uart model state
    logic [7:0] sent_q[$];
    int         tx_wait;
    logic       done_raised;
    logic       prev_start;
    logic       had_byte;
    int         low_run;
    int         min_gap;
    int         rx_gap;

    uart_fifo_bridge #(.FIFO_DEPTH_LOG2(2)) dut (
        .clk(clk), .rst(rst), .tx_push(tx_push), .tx_data(tx_data),
        .tx_full(tx_full), .tx_busy(tx_busy), .rx_pop(rx_pop), .rx_data(rx_data),
        .rx_empty(rx_empty), .start_tx(start_tx), .tx_value(tx_value),
        .tx_done(tx_done), .rx_available(rx_available), .rx_value(rx_value),
        .rx_clear(rx_clear)
`ifdef UART_FIFO_LEVEL_EN
        , .tx_level(tx_level), .rx_level(rx_level)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; tx_push = 1'b0; tx_data = 8'h00; rx_pop = 1'b0;
        tx_done = 1'b0; rx_available = 1'b0; rx_value = 8'h00;
        tick(); tick();
        rst = 1'b0;
        sent_q.delete(); tx_wait = 0; done_raised = 1'b0; prev_start = 1'b0;
        had_byte = 1'b0; low_run = 0; min_gap = 1000; rx_gap = 0;
    endtask

    // Behavioural uart transmitter: answers start_tx after a random delay,
    // keeps tx_done high until start_tx falls, and records gaps between bytes.
    task automatic uart_tx_step();
        done_raised = 1'b0;
        if (!tx_done && start_tx) begin
            if (tx_wait == 0) begin
                sent_q.push_back(tx_value);
                tx_done = 1'b1;
                done_raised = 1'b1;
                tx_wait = $urandom_range(0, 3);
            end else begin
                tx_wait--;
            end
        end else if (tx_done && !start_tx) begin
            tx_done = 1'b0;
        end
        if (!start_tx) begin
            low_run++;
        end else begin
            if (!prev_start && had_byte && low_run < min_gap) min_gap = low_run;
            low_run = 0;
            had_byte = 1'b1;
        end
        prev_start = start_tx;
    endtask

    // Behavioural uart receiver: presents a random byte, withdraws it once
    // rx_clear is seen, then idles a random number of cycles.
    task automatic uart_rx_step();
        if (rx_available && rx_clear) begin
            rx_available = 1'b0;
        end else if (!rx_available && !rx_clear) begin
            if (rx_gap == 0) begin
                rx_available = 1'b1;
                rx_value = 8'($urandom);
                rx_gap = $urandom_range(0, 2);
            end else begin
                rx_gap--;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (start_tx !== 1'b0) begin n_fail++; $display("FAIL reset_start_tx got=%0h exp=0", start_tx); end
        n_checks++; if (rx_clear !== 1'b0) begin n_fail++; $display("FAIL reset_rx_clear got=%0h exp=0", rx_clear); end
        n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL reset_rx_empty got=%0h exp=1", rx_empty); end
        n_checks++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL reset_tx_full got=%0h exp=0", tx_full); end
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_tx_busy got=%0h exp=0", tx_busy); end
        n_checks++; if (tx_value !== 8'h00) begin n_fail++; $display("FAIL reset_tx_value got=%0h exp=0", tx_value); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got=%0h exp=0", rx_data); end
`ifdef UART_FIFO_LEVEL_EN
        n_checks++; if (tx_level !== 3'd0) begin n_fail++; $display("FAIL reset_tx_level got=%0d exp=0", tx_level); end
        n_checks++; if (rx_level !== 3'd0) begin n_fail++; $display("FAIL reset_rx_level got=%0d exp=0", rx_level); end
`endif
    endtask

    task automatic test_single_tx();
        apply_reset();
        tx_push = 1'b1; tx_data = 8'hA5;
        tick();
        tx_push = 1'b0;
        n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_k got=%0h exp=1", tx_busy); end
        n_checks++; if (start_tx !== 1'b0) begin n_fail++; $display("FAIL single_start_k got=%0h exp=0", start_tx); end
        tick();
        n_checks++; if (start_tx !== 1'b1) begin n_fail++; $display("FAIL single_start_k1 got=%0h exp=1", start_tx); end
        n_checks++; if (tx_value !== 8'hA5) begin n_fail++; $display("FAIL single_value got=%0h exp=a5", tx_value); end
        tick(); tick();
        n_checks++; if (start_tx !== 1'b1) begin n_fail++; $display("FAIL single_hold got=%0h exp=1", start_tx); end
        tx_done = 1'b1;
        tick();
        n_checks++; if (start_tx !== 1'b0) begin n_fail++; $display("FAIL single_drop got=%0h exp=0", start_tx); end
        tx_push = 1'b1; tx_data = 8'h5A;
        tick();
        tx_push = 1'b0;
        tick();
        n_checks++; if (start_tx !== 1'b0) begin n_fail++; $display("FAIL single_no_rearm_done_hi got=%0h exp=0", start_tx); end
        tx_done = 1'b0;
        tick();
        n_checks++; if (start_tx !== 1'b0) begin n_fail++; $display("FAIL single_gap2 got=%0h exp=0", start_tx); end
        tick();
        n_checks++; if (start_tx !== 1'b1) begin n_fail++; $display("FAIL single_rearm got=%0h exp=1", start_tx); end
        n_checks++; if (tx_value !== 8'h5A) begin n_fail++; $display("FAIL single_value2 got=%0h exp=5a", tx_value); end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got=%0h exp=0", tx_busy); end
    endtask

    task automatic test_tx_full();
        int cyc;
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            tx_push = 1'b1; tx_data = 8'(i);
            tick();
            if (i == 3) begin
                n_checks++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL full_after3 got=%0h exp=0", tx_full); end
            end
            if (i >= 4) begin
                n_checks++; if (tx_full !== 1'b1) begin n_fail++; $display("FAIL full_after%0d got=%0h exp=1", i, tx_full); end
            end
        end
        tx_push = 1'b0;
        cyc = 0;
        while (!(sent_q.size() >= 4 && !tx_busy && !tx_done) && cyc < 300) begin
            uart_tx_step(); tick(); cyc++;
        end
        n_checks++; if (cyc >= 300) begin n_fail++; $display("FAIL full_timeout got=%0d exp<300", cyc); end
        n_checks++; if (sent_q.size() != 4) begin n_fail++; $display("FAIL full_count got=%0d exp=4", sent_q.size()); end
        for (int i = 0; i < 4 && i < sent_q.size(); i++) begin
            n_checks++; if (sent_q[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL full_order[%0d] got=%0h exp=%0h", i, sent_q[i], i + 1); end
        end
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_end got=%0h exp=0", tx_busy); end
        n_checks++; if (min_gap < 2) begin n_fail++; $display("FAIL full_gap got=%0d exp>=2", min_gap); end
    endtask

    task automatic test_random_tx();
        logic [7:0] ref_q[$];
        int occ;
        int cyc;
        logic push_ok;
        apply_reset();
        occ = 0;
        for (int c = 0; c < 400; c++) begin
            uart_tx_step();
            tx_push = (c < 300) && ($urandom_range(0, 2) != 0);
            tx_data = 8'($urandom);
            push_ok = tx_push && (occ < DEPTH);
            if (push_ok) ref_q.push_back(tx_data);
            tick();
            occ = occ + (push_ok ? 1 : 0) - (done_raised ? 1 : 0);
            n_checks++; if (tx_full !== (occ == DEPTH)) begin n_fail++; $display("FAIL rtx_full cyc=%0d got=%0h exp=%0h", c, tx_full, occ == DEPTH); end
`ifdef UART_FIFO_LEVEL_EN
            n_checks++; if (tx_level !== 3'(occ)) begin n_fail++; $display("FAIL rtx_level cyc=%0d got=%0d exp=%0d", c, tx_level, occ); end
`endif
        end
        tx_push = 1'b0;
        cyc = 0;
        while ((tx_busy || tx_done) && cyc < 300) begin
            uart_tx_step(); tick(); cyc++;
        end
        n_checks++; if (cyc >= 300) begin n_fail++; $display("FAIL rtx_timeout got=%0d exp<300", cyc); end
        n_checks++; if (sent_q.size() != ref_q.size()) begin n_fail++; $display("FAIL rtx_count got=%0d exp=%0d", sent_q.size(), ref_q.size()); end
        for (int i = 0; i < ref_q.size() && i < sent_q.size(); i++) begin
            n_checks++; if (sent_q[i] !== ref_q[i]) begin n_fail++; $display("FAIL rtx_order[%0d] got=%0h exp=%0h", i, sent_q[i], ref_q[i]); end
        end
        n_checks++; if (min_gap < 2) begin n_fail++; $display("FAIL rtx_gap got=%0d exp>=2", min_gap); end
    endtask

`ifdef UART_FIFO_LEVEL_EN
    task automatic test_level();
        int cyc;
        apply_reset();
        tx_push = 1'b1; tx_data = 8'h11;
        tick();
        n_checks++; if (tx_level !== 3'd1) begin n_fail++; $display("FAIL level_1 got=%0d exp=1", tx_level); end
        tx_data = 8'h22;
        tick();
        n_checks++; if (tx_level !== 3'd2) begin n_fail++; $display("FAIL level_2 got=%0d exp=2", tx_level); end
        tx_data = 8'h33; tx_done = 1'b1;
        tick();
        tx_push = 1'b0;
        n_checks++; if (tx_level !== 3'd2) begin n_fail++; $display("FAIL level_3 got=%0d exp=2", tx_level); end
        cyc = 0;
        while ((tx_busy || tx_done) && cyc < 100) begin
            uart_tx_step(); tick(); cyc++;
        end
        n_checks++; if (tx_level !== 3'd0) begin n_fail++; $display("FAIL level_drained got=%0d exp=0", tx_level); end
    endtask
`endif

    task automatic test_rx_drain();
        apply_reset();
        rx_available = 1'b1; rx_value = 8'h3C;
        tick();
        n_checks++; if (rx_clear !== 1'b1) begin n_fail++; $display("FAIL drain_clear got=%0h exp=1", rx_clear); end
        n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL drain_data got=%0h exp=3c", rx_data); end
        n_checks++; if (rx_empty !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%0h exp=0", rx_empty); end
        tick();
        n_checks++; if (rx_clear !== 1'b1) begin n_fail++; $display("FAIL drain_hold got=%0h exp=1", rx_clear); end
        rx_available = 1'b0;
        tick();
        n_checks++; if (rx_clear !== 1'b0) begin n_fail++; $display("FAIL drain_release got=%0h exp=0", rx_clear); end
        n_checks++; if (rx_empty !== 1'b0) begin n_fail++; $display("FAIL drain_single got=%0h exp=0", rx_empty); end
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
        n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL drain_pop got=%0h exp=1", rx_empty); end
    endtask

    task automatic test_rx_full();
        logic [7:0] b [5];
        apply_reset();
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            rx_available = 1'b1; rx_value = b[i];
            tick();
            n_checks++; if (rx_clear !== 1'b1) begin n_fail++; $display("FAIL rxf_clear[%0d] got=%0h exp=1", i, rx_clear); end
            rx_available = 1'b0;
            tick();
            n_checks++; if (rx_clear !== 1'b0) begin n_fail++; $display("FAIL rxf_release[%0d] got=%0h exp=0", i, rx_clear); end
        end
        rx_available = 1'b1; rx_value = b[4];
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (rx_clear !== 1'b0) begin n_fail++; $display("FAIL rxf_backpressure got=%0h exp=0", rx_clear); end
        end
        n_checks++; if (rx_data !== b[0]) begin n_fail++; $display("FAIL rxf_head got=%0h exp=%0h", rx_data, b[0]); end
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
        n_checks++; if (rx_clear !== 1'b0) begin n_fail++; $display("FAIL rxf_pop_edge got=%0h exp=0", rx_clear); end
        tick();
        n_checks++; if (rx_clear !== 1'b1) begin n_fail++; $display("FAIL rxf_fifth got=%0h exp=1", rx_clear); end
        rx_available = 1'b0;
        tick();
        for (int i = 1; i < 5; i++) begin
            n_checks++; if (rx_data !== b[i]) begin n_fail++; $display("FAIL rxf_order[%0d] got=%0h exp=%0h", i, rx_data, b[i]); end
            rx_pop = 1'b1;
            tick();
            rx_pop = 1'b0;
        end
        n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL rxf_empty_end got=%0h exp=1", rx_empty); end
    endtask

    task automatic test_random_rx();
        logic [7:0] ref_q[$];
        logic pop_ok, exp_push, pushed, prev_clear, avail_pre;
        logic [7:0] val;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            uart_rx_step();
            rx_pop = ($urandom_range(0, 3) == 0);
            pop_ok = rx_pop && (ref_q.size() > 0);
            avail_pre = rx_available;
            prev_clear = rx_clear;
            val = rx_value;
            exp_push = avail_pre && !prev_clear && (ref_q.size() < DEPTH);
            tick();
            pushed = rx_clear && !prev_clear;
            n_checks++; if (pushed !== exp_push) begin n_fail++; $display("FAIL rrx_push cyc=%0d got=%0h exp=%0h", c, pushed, exp_push); end
            if (pop_ok) void'(ref_q.pop_front());
            if (exp_push) ref_q.push_back(val);
            n_checks++; if (rx_empty !== (ref_q.size() == 0)) begin n_fail++; $display("FAIL rrx_empty cyc=%0d got=%0h exp=%0h", c, rx_empty, ref_q.size() == 0); end
            if (ref_q.size() > 0) begin
                n_checks++; if (rx_data !== ref_q[0]) begin n_fail++; $display("FAIL rrx_data cyc=%0d got=%0h exp=%0h", c, rx_data, ref_q[0]); end
            end
`ifdef UART_FIFO_LEVEL_EN
            n_checks++; if (rx_level !== 3'(ref_q.size())) begin n_fail++; $display("FAIL rrx_level cyc=%0d got=%0d exp=%0d", c, rx_level, ref_q.size()); end
`endif
        end
        rx_pop = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        tx_push = 1'b1; tx_data = 8'h77;
        tick();
        tx_push = 1'b0;
        tick();
        rx_available = 1'b1; rx_value = 8'h42;
        tick();
        n_checks++; if (start_tx !== 1'b1) begin n_fail++; $display("FAIL mid_pre_start got=%0h exp=1", start_tx); end
        n_checks++; if (rx_clear !== 1'b1) begin n_fail++; $display("FAIL mid_pre_clear got=%0h exp=1", rx_clear); end
        rst = 1'b1;
        tick();
        n_checks++; if (start_tx !== 1'b0) begin n_fail++; $display("FAIL mid_start got=%0h exp=0", start_tx); end
        n_checks++; if (rx_clear !== 1'b0) begin n_fail++; $display("FAIL mid_clear got=%0h exp=0", rx_clear); end
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%0h exp=0", tx_busy); end
        n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL mid_rx_empty got=%0h exp=1", rx_empty); end
        rst = 1'b0; rx_available = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_tx();
        test_tx_full();
        test_random_tx();
`ifdef UART_FIFO_LEVEL_EN
        test_level();
`endif
        test_rx_drain();
        test_rx_full();
        test_random_rx();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
